fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DW, default 32: data width; SHALL equal the width of the FIFO being drained.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  when high, the block may issue FIFO reads in STREAM state.
REQ-005 flush  input  1  level request to discard all FIFO contents and buffered words.
REQ-006 fifo_empty  input  1  empty flag of the drained FIFO.
REQ-007 fifo_dout  input  DW  FIFO read data; valid exactly one cycle after a cycle with fifo_ren=1 and fifo_empty=0.
REQ-008 fifo_ren  output  1  FIFO read enable.
REQ-009 m_valid  output  1  stream word available.
REQ-010 m_data  output  DW  stream word.
REQ-011 m_ready  input  1  downstream accepts; transfer occurs when m_valid && m_ready.
REQ-012 flush_done  output  1  one-cycle pulse on flush completion.

Function
REQ-013 The FSM SHALL have states IDLE, STREAM and FLUSH.
REQ-014 Transitions: IDLE->STREAM when en && !flush; STREAM->IDLE when !en && inflight==0 && occ==0; any state->FLUSH when flush.
REQ-015 Transitions from FLUSH: FLUSH->IDLE when fifo_empty && inflight==0, with flush_done=1 for that cycle.
REQ-016 inflight SHALL be a 1-bit register, set in the cycle after fifo_ren && !fifo_empty; it marks fifo_dout capture this cycle.
REQ-017 The output buffer SHALL hold 2 entries; occ is its occupancy (0..2); ordering is FIFO.
REQ-018 In STREAM, fifo_ren = en && !fifo_empty && (occ + inflight - pop) < 2, where pop = m_valid && m_ready; fifo_ren is combinational from m_ready.
REQ-019 In STREAM, the block SHALL sustain one word per cycle when the source is non-empty and m_ready=1 continuously.
REQ-020 First-word latency SHALL be 2 cycles: fifo_ren in cycle t, m_valid in cycle t+2.
REQ-021 m_valid = (occ != 0); m_data = oldest entry; m_data SHALL be stable while m_valid && !m_ready.
REQ-022 Simultaneous capture and pop SHALL leave occ unchanged; occ SHALL never exceed 2 and no word shall be lost or duplicated.
REQ-023 In FLUSH: fifo_ren = !fifo_empty; occ is cleared on entry; captured words are discarded; m_valid=0.
REQ-024 fifo_ren SHALL never be asserted while fifo_empty=1.
REQ-025 In IDLE, fifo_ren=0; buffered words still drain to m_*.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, occ=0, inflight=0, fifo_ren=0, m_valid=0, m_data=0 and flush_done=0.
REQ-027 A reset during an in-flight read SHALL drop that word; the FIFO shares rst_n and is reset with the block.

Configuration
REQ-028 With FIFO_RD_STATS_EN defined, the block SHALL add a 16-bit output rd_count that increments on each m_valid && m_ready, wraps 0xFFFF->0, resets to 0 and is unaffected by flush.
REQ-029 Without FIFO_RD_STATS_EN, rd_count and its counter logic SHALL be absent.

Structure
REQ-030 Package fifo_rd_pkg SHALL hold the state enum typedef (IDLE, STREAM, FLUSH) and the constant OBUF_DEPTH=2.
REQ-031 The 2-entry buffer SHALL be the sub-module fifo_rd_obuf (push, pop, data, occ).

Verification
REQ-032 Bench SHALL cover: FIFO preloaded 0x1..0x8, en=1, m_ready=1 -> 8 words in order on 8 consecutive cycles, first word 2 cycles after the first fifo_ren.
REQ-033 Bench SHALL cover: 4 words, m_ready=0 for 5 cycles then 1 -> m_valid held with m_data=0x1 stable; fifo_ren stops after 2 captures; all 4 words delivered in order.
REQ-034 Bench SHALL cover: m_ready toggling 1/0 per cycle over 16 words -> no loss or duplication, and fifo_ren never asserted while fifo_empty=1.
REQ-035 Bench SHALL cover: 6 words, 2 already buffered, flush pulsed -> m_valid=0 next cycle, FIFO emptied, single flush_done pulse, state=IDLE.
REQ-036 Bench SHALL cover: rst_n=0 for 1 cycle with inflight=1 and occ=2 -> all outputs 0 the next cycle.
REQ-037 Bench SHALL cover, with FIFO_RD_STATS_EN: 65537 transfers -> rd_count=1.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared types and constants for the FIFO read-streamer slice.
//   rd_state_e  : streamer FSM states (IDLE, STREAM, FLUSH)
//   OBUF_DEPTH  : number of entries in the output skid buffer
//   OCC_W/PTR_W : widths of the buffer occupancy count and entry pointers
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

  localparam int OBUF_DEPTH = 2;
  localparam int OCC_W      = $clog2(OBUF_DEPTH + 1);
  localparam int PTR_W      = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_obuf.sv
// -----------------------------------------------------------------------------
// fifo_rd_obuf
// Small first-in/first-out output buffer (OBUF_DEPTH entries) that absorbs
// words already requested from the upstream FIFO while the stream is stalled.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (clears data too)
//   clear        : drop all buffered words (pointers and occupancy to 0)
//   push         : write push_data at the tail
//   push_data    : word to buffer
//   pop          : remove the head entry
//   pop_data     : head entry (oldest word), valid when occ != 0
//   occ          : number of buffered words
// -----------------------------------------------------------------------------
module fifo_rd_obuf
  import fifo_rd_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [DW-1:0]    pop_data,
  output logic [OCC_W-1:0] occ
);

  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(OBUF_DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg;
  logic [DW-1:0]    entry_q [OBUF_DEPTH];
  logic             do_push;
  logic             do_pop;

  // A push into a full buffer is only legal when the head leaves in the
  // same cycle; the caller guarantees this, the guard just keeps state sane.
  assign do_pop  = pop && (occ_reg != '0);
  assign do_push = push && ((occ_reg != FULL_OCC) || do_pop);

  // One register per entry; the write pointer selects which one loads.
  for (genvar gi = 0; gi < OBUF_DEPTH; gi++) begin : gen_entry
    logic [DW-1:0] entry_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        entry_reg <= '0;
      end else if (do_push && !clear && (wr_ptr_reg == PTR_W'(gi))) begin
        entry_reg <= push_data;
      end
    end

    assign entry_q[gi] = entry_reg;
  end

  // Pointers wrap naturally because OBUF_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ_reg <= occ_reg + OCC_W'(1);
        2'b01:   occ_reg <= occ_reg - OCC_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign pop_data = entry_q[rd_ptr_reg];
  assign occ      = occ_reg;

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Drains a synchronous FIFO (one-cycle read latency) onto a valid/ready
// stream at up to one word per cycle, with a flush mode that discards both
// the FIFO contents and any buffered words.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   en          : allow FIFO reads while streaming
//   flush       : level request to discard everything
//   fifo_empty  : FIFO empty flag
//   fifo_dout   : FIFO read data (valid the cycle after an accepted read)
//   fifo_ren    : FIFO read enable
//   m_valid     : stream word available
//   m_data      : stream word (oldest buffered)
//   m_ready     : downstream accept
//   flush_done  : one-cycle pulse when the flush completes
//   rd_count    : (only with FIFO_RD_STATS_EN) 16-bit wrapping count of
//                 stream transfers
// Build option: define FIFO_RD_STATS_EN to add the rd_count output.
// -----------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          flush,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_ren,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic          flush_done
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]   rd_count
`endif
);

  rd_state_e        state_reg;
  rd_state_e        state_next;
  logic             inflight_reg;
  logic [OCC_W-1:0] occ;
  logic             pop;
  logic             capture;
  logic             obuf_clear;
  logic [2:0]       fill_after_pop;
  logic             room;

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;

  // Words landing while flushing are thrown away instead of buffered.
  assign capture    = inflight_reg && (state_reg != FLUSH);
  assign obuf_clear = flush || (state_reg == FLUSH);

  // Count the word already on its way (inflight) as occupying a slot, and
  // credit a slot freed by this cycle's pop so back-to-back streaming works.
  assign fill_after_pop = 3'(occ) + 3'(inflight_reg) - 3'(pop);
  assign room           = fill_after_pop < 3'(OBUF_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= fifo_ren && !fifo_empty;
    end
  end

  always_comb begin
    state_next = state_reg;
    fifo_ren   = 1'b0;
    flush_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flush)   state_next = FLUSH;
        else if (en) state_next = STREAM;
      end
      STREAM: begin
        fifo_ren = en && !fifo_empty && room;
        if (flush) begin
          state_next = FLUSH;
        end else if (!en && !inflight_reg && (occ == '0)) begin
          state_next = IDLE;
        end
      end
      FLUSH: begin
        fifo_ren = !fifo_empty;
        // A held flush request keeps draining; completion waits for the
        // last outstanding read to land.
        if (!flush && fifo_empty && !inflight_reg) begin
          state_next = IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  fifo_rd_obuf #(
    .DW(DW)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (obuf_clear),
    .push      (capture),
    .push_data (fifo_dout),
    .pop       (pop),
    .pop_data  (m_data),
    .occ       (occ)
  );

`ifdef FIFO_RD_STATS_EN
  logic [15:0] rd_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count_reg <= '0;
    end else if (pop) begin
      rd_count_reg <= rd_count_reg + 16'd1;
    end
  end

  assign rd_count = rd_count_reg;
`endif

endmodule
